// File: rtl/data_memory_responder.sv
// Data memory for the MEM stage: B/H/W stores with lane merge, sign/zero-extended loads.
// Response WAIT_STATES+1 cycles after acceptance; stall_o freezes the pipeline until then.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic        MemRW_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rsp_valid_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam bit         NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0] WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        req_store;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic        acc_store;
  logic [2:0]  acc_f3;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        go_resp;

  // With zero wait states the access happens on the acceptance edge itself,
  // so the live inputs are used instead of the not-yet-captured copy.
  always_comb begin
    acc_store = req_store;
    acc_f3    = req_f3;
    acc_addr  = req_addr;
    acc_wdata = req_wdata;
    if (state == IDLE) begin
      acc_store = MemRW_i;
      acc_f3    = funct3_i;
      acc_addr  = addr_i;
      acc_wdata = wdata_i;
    end
  end

  assign go_resp = ((state == IDLE) && req_valid_i && NO_WAIT) ||
                   ((state == WAIT) && (cnt == 4'd0));

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          unused_addr;

  assign word_idx    = acc_addr[AW+1:2];
  assign lane        = acc_addr[1:0];
  assign unused_addr = ^acc_addr[31:AW+2];

  logic illegal_f3;
  logic misaligned;
  logic acc_err;

  assign illegal_f3 = (acc_f3 == 3'b011) || (acc_f3[2:1] == 2'b11) ||
                      (acc_store && acc_f3[2]);
  assign misaligned = ((acc_f3[1:0] == 2'b01) && lane[0]) ||
                      ((acc_f3[1:0] == 2'b10) && (lane != 2'b00));
  assign acc_err    = illegal_f3 || misaligned;

  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {lane, 3'b000};
  assign rd_byte  = rd_shift[7:0];
  assign rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = rd_word;
    case (acc_f3)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'd0, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'd0, rd_half};
      default: load_data = rd_word;
    endcase
  end

  logic [3:0]  byte_en;
  logic [31:0] st_data;
  logic        mem_we;

  // Store data is replicated across lanes; byte_en picks the lanes that change.
  always_comb begin
    byte_en = 4'b1111;
    st_data = acc_wdata;
    case (acc_f3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << lane;
        st_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        st_data = acc_wdata;
      end
    endcase
  end

  assign mem_we = go_resp && acc_store && !acc_err;

  // Memory is deliberately not reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][b*8 +: 8] <= st_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      req_store   <= 1'b0;
      req_f3      <= 3'd0;
      req_addr    <= 32'd0;
      req_wdata   <= 32'd0;
      rdata_o     <= 32'd0;
      rsp_valid_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      rsp_valid_o <= go_resp;
      err_o       <= go_resp && acc_err;
      rdata_o     <= (go_resp && !acc_store && !acc_err) ? load_data : 32'd0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            req_store <= MemRW_i;
            req_f3    <= funct3_i;
            req_addr  <= addr_i;
            req_wdata <= wdata_i;
            if (NO_WAIT) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_o = ((state == IDLE) && req_valid_i) || (state == WAIT);

endmodule
